mig_7series_v4_0_axi_mc_cmd_arbiter: RTL
========================================

MIG_7SERIES_V4_0_AXI_MC_CMD_ARBITER -- requirements
Module: mig_7series_v4_0_axi_mc_cmd_arbiter

Interface
REQ-001 SHALL have parameter C_ADDR_WIDTH, default 30, the command address width in bits.
REQ-002 SHALL have parameter C_STICKY_LIMIT, default 4, the maximum consecutive transactions granted to one side while the other waits (used only with MIG_AXI_ARB_STICKY_EN).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port wr_cmd_en, input, 1 bit: the write requester presents a command.
REQ-006 SHALL have port wr_cmd_last, input, 1 bit: qualified by wr_cmd_en; marks the final command of a write transaction.
REQ-007 SHALL have port wr_cmd_addr, input, C_ADDR_WIDTH bits: the write command address.
REQ-008 SHALL have port wr_cmd_full, output, 1 bit: write command not accepted this cycle.
REQ-009 SHALL have ports rd_cmd_en, rd_cmd_last, rd_cmd_addr and rd_cmd_full with the same directions, widths and meanings as REQ-005 to REQ-008, for the read side.
REQ-010 SHALL have port app_en, output, 1 bit: command valid toward the MC.
REQ-011 SHALL have port app_cmd, output, 3 bits: 3'b000 for write, 3'b001 for read.
REQ-012 SHALL have port app_addr, output, C_ADDR_WIDTH bits: the command address toward the MC.
REQ-013 SHALL have port app_rdy, input, 1 bit: the MC accepts the command.
REQ-014 SHALL have ports wr_granted and rd_granted, output, 1 bit each: registered status of the current owner.

Function
REQ-015 SHALL implement a registered FSM with states IDLE, WR, and RD.
REQ-016 In IDLE: app_en=0, wr_cmd_full=1, rd_cmd_full=1.
REQ-017 IDLE transitions: only wr_cmd_en -> WR; only rd_cmd_en -> RD; both -> the side opposite the last_served pointer; neither -> IDLE.
REQ-018 In WR: app_en=wr_cmd_en, app_cmd=000, app_addr=wr_cmd_addr, wr_cmd_full=~app_rdy, rd_cmd_full=1. RD mirrors this with app_cmd=001.
REQ-019 Accept = app_en & app_rdy; done = accept & the owner's *_cmd_last.
REQ-020 Outputs in WR and RD SHALL be combinational from the inputs, with zero-cycle accept latency; grant changes take effect the cycle after the transition.
REQ-021 Ownership SHALL NOT change before done; a transaction is never interleaved.
REQ-022 On done, last_served SHALL be set to the owner.
REQ-023 On done, next state SHALL be the other side if its *_cmd_en=1 in that cycle; else the same side if its *_cmd_en=1 in that cycle; else IDLE.
REQ-024 app_rdy=0 SHALL hold the state and outputs; no command is dropped.
REQ-025 wr_granted=1 exactly when state=WR; rd_granted=1 exactly when state=RD.

Reset
REQ-026 Asserting reset, at any time including mid-transaction, SHALL immediately force: state=IDLE, last_served=RD (write wins the first tie), streak=0, app_en=0, both *_cmd_full=1, both *_granted=0.
REQ-027 The first transition after reset deassertion SHALL occur on the first rising edge with reset low.

Configuration
REQ-028 With macro MIG_AXI_ARB_STICKY_EN defined, the block SHALL add a streak counter of width clog2(C_STICKY_LIMIT+1).
REQ-029 With MIG_AXI_ARB_STICKY_EN defined, the streak counter SHALL increment on each done and clear on every change of owner or on entry to IDLE.
REQ-030 With MIG_AXI_ARB_STICKY_EN defined, REQ-023 SHALL be replaced by: on done, stay with the same side if its *_cmd_en=1 and streak+1 < C_STICKY_LIMIT; else the other side if it requests; else the same side if it requests; else IDLE.
REQ-031 Without MIG_AXI_ARB_STICKY_EN, there SHALL be no streak counter and REQ-023 applies (strict alternation under contention).

Verification
REQ-032 After reset, assert wr_cmd_en and rd_cmd_en together with last=1 and app_rdy=1 -> WR granted first; app_cmd 000, then 001, alternating every transaction.
REQ-033 With write 4-command transaction (last on the 4th), rd_cmd_en asserted from cycle 2, and app_rdy=1 -> four consecutive write accepts with rd_cmd_full=1 throughout, then RD.
REQ-034 Hold app_rdy=0 for 3 cycles mid-transaction -> app_en, app_addr and app_cmd stable and owner unchanged; accept only when app_rdy=1.
REQ-035 Assert reset during the 2nd command of a read transaction -> same cycle: app_en=0, both full=1, rd_granted=0 after the edge; with write pending after release, WR wins.
REQ-036 With MIG_AXI_ARB_STICKY_EN and C_STICKY_LIMIT=4, both sides continuously requesting single-command transactions -> 4 reads, then 4 writes, repeating; without the macro -> 1:1 alternation.
REQ-037 Only rd_cmd_en, back-to-back transactions, app_rdy=1 -> RD held across done with no IDLE bubble; accepts on every cycle.

Source files
------------

// File: rtl/mig_7series_v4_0_axi_mc_cmd_arbiter_if.sv
// Command bus between the AXI write/read command paths, the arbiter and the MC app port.
interface mig_7series_v4_0_axi_mc_cmd_arbiter_if #(
  parameter int unsigned C_ADDR_WIDTH = 30
);
  logic                    wr_cmd_en;
  logic                    wr_cmd_last;
  logic [C_ADDR_WIDTH-1:0] wr_cmd_addr;
  logic                    wr_cmd_full;
  logic                    rd_cmd_en;
  logic                    rd_cmd_last;
  logic [C_ADDR_WIDTH-1:0] rd_cmd_addr;
  logic                    rd_cmd_full;
  logic                    app_en;
  logic [2:0]              app_cmd;
  logic [C_ADDR_WIDTH-1:0] app_addr;
  logic                    app_rdy;
  logic                    wr_granted;
  logic                    rd_granted;

  modport slave (
    input  wr_cmd_en, wr_cmd_last, wr_cmd_addr,
    input  rd_cmd_en, rd_cmd_last, rd_cmd_addr,
    input  app_rdy,
    output wr_cmd_full, rd_cmd_full,
    output app_en, app_cmd, app_addr,
    output wr_granted, rd_granted
  );

  modport master (
    output wr_cmd_en, wr_cmd_last, wr_cmd_addr,
    output rd_cmd_en, rd_cmd_last, rd_cmd_addr,
    output app_rdy,
    input  wr_cmd_full, rd_cmd_full,
    input  app_en, app_cmd, app_addr,
    input  wr_granted, rd_granted
  );
endinterface

// File: rtl/mig_7series_v4_0_axi_mc_cmd_arbiter.sv
// Write/read command arbiter toward the MC; whole transactions are never interleaved.
// Define MIG_AXI_ARB_STICKY_EN to let one side keep ownership for up to C_STICKY_LIMIT transactions.
module mig_7series_v4_0_axi_mc_cmd_arbiter #(
  parameter int unsigned C_ADDR_WIDTH   = 30,
  parameter int unsigned C_STICKY_LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  mig_7series_v4_0_axi_mc_cmd_arbiter_if.slave bus
);

  if (C_STICKY_LIMIT == 0) begin : g_bad_limit
    $error("C_STICKY_LIMIT must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic                    last_rd_q, last_rd_d;
  logic                    wr_granted_q, rd_granted_q;
  logic                    own_en, own_last, oth_en, done;
  logic [C_ADDR_WIDTH-1:0] addr_sel;

`ifdef MIG_AXI_ARB_STICKY_EN
  localparam int unsigned STREAK_W = $clog2(C_STICKY_LIMIT + 1);
  logic [STREAK_W-1:0] streak_q, streak_d;
`endif

  always_comb begin
    own_en   = 1'b0;
    own_last = 1'b0;
    oth_en   = 1'b0;
    unique case (state_q)
      WR: begin
        own_en   = bus.wr_cmd_en;
        own_last = bus.wr_cmd_last;
        oth_en   = bus.rd_cmd_en;
      end
      RD: begin
        own_en   = bus.rd_cmd_en;
        own_last = bus.rd_cmd_last;
        oth_en   = bus.wr_cmd_en;
      end
      default: ;
    endcase
  end

  assign done     = own_en & bus.app_rdy & own_last;
  assign addr_sel = (state_q == RD) ? bus.rd_cmd_addr : bus.wr_cmd_addr;

  assign bus.app_en      = own_en;
  assign bus.app_cmd     = (state_q == RD) ? 3'b001 : 3'b000;
  assign bus.app_addr    = addr_sel;
  assign bus.wr_cmd_full = ~((state_q == WR) & bus.app_rdy);
  assign bus.rd_cmd_full = ~((state_q == RD) & bus.app_rdy);
  assign bus.wr_granted  = wr_granted_q;
  assign bus.rd_granted  = rd_granted_q;

  always_comb begin
    state_d   = state_q;
    last_rd_d = last_rd_q;
    unique case (state_q)
      IDLE: begin
        if (bus.wr_cmd_en && bus.rd_cmd_en) state_d = last_rd_q ? WR : RD;
        else if (bus.wr_cmd_en)             state_d = WR;
        else if (bus.rd_cmd_en)             state_d = RD;
      end
      WR, RD: begin
        // done implies the owner is requesting, so "stay" is the fallback.
        if (done) begin
          last_rd_d = (state_q == RD);
`ifdef MIG_AXI_ARB_STICKY_EN
          if (int'(streak_q) + 1 >= int'(C_STICKY_LIMIT) && oth_en)
            state_d = (state_q == WR) ? RD : WR;
`else
          if (oth_en) state_d = (state_q == WR) ? RD : WR;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef MIG_AXI_ARB_STICKY_EN
  // Saturates at the limit so a lone requester cannot wrap the count.
  always_comb begin
    streak_d = streak_q;
    if (state_q == IDLE || state_d != state_q)
      streak_d = '0;
    else if (done && int'(streak_q) < int'(C_STICKY_LIMIT))
      streak_d = streak_q + 1'b1;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      last_rd_q    <= 1'b1;
      wr_granted_q <= 1'b0;
      rd_granted_q <= 1'b0;
`ifdef MIG_AXI_ARB_STICKY_EN
      streak_q     <= '0;
`endif
    end else begin
      state_q      <= state_d;
      last_rd_q    <= last_rd_d;
      wr_granted_q <= (state_d == WR);
      rd_granted_q <= (state_d == RD);
`ifdef MIG_AXI_ARB_STICKY_EN
      streak_q     <= streak_d;
`endif
    end
  end

endmodule
